// File: rtl/finder_pkg.sv
// rtl/finder_pkg.sv - shared types, flag masks and byte helpers for the dictionary finder
package finder_pkg;

  typedef enum logic [3:0] {
    IDLE, TLEN, LNK0, LNK1, FLAG, CMPT, CMPD, NEXT, DONE
  } finder_sts;

  localparam logic [7:0] F_IMM     = 8'h80;
  localparam logic [7:0] F_HID     = 8'h40;
  localparam logic [7:0] F_LEN     = 8'h1f;
  localparam logic [7:0] DELIM_NUL = 8'h00;
  localparam logic [7:0] DELIM_SP  = 8'h20;

  // Only 'a'..'z' move; every other byte value passes through untouched.
  function automatic logic [7:0] fold_uc(input logic [7:0] b);
    fold_uc = (b >= 8'h61 && b <= 8'h7a) ? (b - 8'h20) : b;
  endfunction

endpackage

// File: rtl/byte_fetch.sv
// rtl/byte_fetch.sv - single outstanding byte read with fixed memory latency
module byte_fetch #(
  parameter int ASZ    = 17,
  parameter int DSZ    = 8,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_i,
  input  logic [ASZ-1:0] addr_i,
  output logic [ASZ-1:0] mem_ai,
  input  logic [DSZ-1:0] mem_vo,
  output logic           vld_o,
  output logic [DSZ-1:0] data_o
);

  localparam int CW = $clog2(RD_LAT + 1);

  logic           pend_q;
  logic [CW-1:0]  cnt_q;
  logic [ASZ-1:0] addr_q;

  // Data is taken straight off the bus in the cycle the latency count expires.
  assign vld_o  = pend_q && (cnt_q == CW'(RD_LAT));
  assign data_o = mem_vo;
  assign mem_ai = addr_q;

  // A new request may be issued in the same cycle the previous byte returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
      addr_q <= '0;
    end else if (req_i) begin
      addr_q <= addr_i;
      pend_q <= 1'b1;
      cnt_q  <= '0;
    end else if (vld_o) begin
      pend_q <= 1'b0;
    end else if (pend_q) begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/word_finder.sv
// rtl/word_finder.sv - walks the linked word list looking for the token at TIB
module word_finder
  import finder_pkg::*;
#(
  parameter int          ASZ       = 17,
  parameter int          DSZ       = 8,
  parameter logic [15:0] NULL_LINK = 16'hffff,
  parameter int          NMAX      = 31,
  parameter int          CASE_FOLD = 0,
  parameter int          RD_LAT    = 1,
  parameter int          MAX_HOPS  = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [ASZ-1:0] tib,
  input  logic [ASZ-1:0] ctx,
  output logic [ASZ-1:0] mem_ai,
  input  logic [DSZ-1:0] mem_vo,
  output logic           bsy,
  output logic           done,
  output logic           hit,
  output logic [ASZ-1:0] pfa,
  output logic           imm,
  output logic           err,
  output finder_sts      st
);

  localparam int TLW = $clog2(NMAX + 2);
  localparam int HW  = $clog2(MAX_HOPS + 1);

  finder_sts      state_q, state_d;
  logic [ASZ-1:0] tib_q, tib_d, lfa_q, lfa_d, pfa_q, pfa_d;
  logic [15:0]    link_q, link_d;
  logic [TLW-1:0] tlen_q, tlen_d, idx_q, idx_d;
  logic [7:0]     flag_q, flag_d, tbyte_q, tbyte_d;
  logic [HW-1:0]  hops_q, hops_d;
  logic           iss_q, iss_d, hit_q, hit_d, imm_q, imm_d, err_q, err_d;

  logic           req, got, fb_vld;
  logic [ASZ-1:0] req_addr;
  logic [DSZ-1:0] fb_data;
  logic [7:0]     byte_v, cmp_t, cmp_m;

  byte_fetch #(.ASZ(ASZ), .DSZ(DSZ), .RD_LAT(RD_LAT)) u_fetch (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req),
    .addr_i (req_addr),
    .mem_ai (mem_ai),
    .mem_vo (mem_vo),
    .vld_o  (fb_vld),
    .data_o (fb_data)
  );

  assign byte_v = fb_data[7:0];
  assign got    = iss_q && fb_vld;
  assign cmp_t  = (CASE_FOLD != 0) ? fold_uc(tbyte_q) : tbyte_q;
  assign cmp_m  = (CASE_FOLD != 0) ? fold_uc(byte_v) : byte_v;

  assign bsy  = (state_q != IDLE) && (state_q != DONE);
  assign done = (state_q == DONE);
  assign hit  = hit_q;
  assign pfa  = pfa_q;
  assign imm  = imm_q;
  assign err  = err_q;
  assign st   = state_q;

  // Every fetching state issues exactly one read on entry, then waits for its byte.
  always_comb begin
    req_addr = '0;
    case (state_q)
      TLEN:    req_addr = tib_q + ASZ'(tlen_q);
      LNK0:    req_addr = lfa_q;
      LNK1:    req_addr = lfa_q + ASZ'(1);
      FLAG:    req_addr = lfa_q + ASZ'(2);
      CMPT:    req_addr = tib_q + ASZ'(idx_q);
      CMPD:    req_addr = lfa_q + ASZ'(3) + ASZ'(idx_q);
      default: req_addr = '0;
    endcase
    req = !iss_q && (state_q inside {TLEN, LNK0, LNK1, FLAG, CMPT, CMPD});
  end

  // Next-state and datapath updates; bytes are acted on only in the cycle they arrive.
  always_comb begin
    state_d = state_q;
    tib_d   = tib_q;
    lfa_d   = lfa_q;
    pfa_d   = pfa_q;
    link_d  = link_q;
    tlen_d  = tlen_q;
    idx_d   = idx_q;
    flag_d  = flag_q;
    tbyte_d = tbyte_q;
    hops_d  = hops_q;
    hit_d   = hit_q;
    imm_d   = imm_q;
    err_d   = err_q;
    iss_d   = req ? 1'b1 : (got ? 1'b0 : iss_q);
    case (state_q)
      IDLE: if (en) begin
        tib_d   = tib;
        lfa_d   = ctx;
        hit_d   = 1'b0;
        imm_d   = 1'b0;
        err_d   = 1'b0;
        pfa_d   = '0;
        tlen_d  = '0;
        hops_d  = '0;
        state_d = TLEN;
      end
      TLEN: if (got) begin
        if (byte_v == DELIM_NUL || byte_v == DELIM_SP) begin
          if (tlen_q == '0 || lfa_q == ASZ'(NULL_LINK)) state_d = DONE;
          else state_d = LNK0;
        end else if (tlen_q == TLW'(NMAX)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tlen_d = tlen_q + TLW'(1);
        end
      end
      LNK0: if (got) begin
        link_d[7:0] = byte_v;
        state_d     = LNK1;
      end
      LNK1: if (got) begin
        link_d[15:8] = byte_v;
        state_d      = FLAG;
      end
      FLAG: if (got) begin
        flag_d = byte_v;
        if ((byte_v & F_HID) != 8'h00 || (byte_v & F_LEN) != 8'(tlen_q)) begin
          state_d = NEXT;
        end else begin
          idx_d   = '0;
          state_d = CMPT;
        end
      end
      CMPT: if (got) begin
        tbyte_d = byte_v;
        state_d = CMPD;
      end
      CMPD: if (got) begin
        if (cmp_t != cmp_m) begin
          state_d = NEXT;
        end else if (idx_q + TLW'(1) == tlen_q) begin
          hit_d   = 1'b1;
          pfa_d   = lfa_q + ASZ'(3) + ASZ'(tlen_q);
          imm_d   = (flag_q & F_IMM) != 8'h00;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + TLW'(1);
          state_d = CMPT;
        end
      end
      NEXT: begin
        hops_d = hops_q + HW'(1);
        if (link_q == NULL_LINK) begin
          state_d = DONE;
        end else if (hops_q + HW'(1) == HW'(MAX_HOPS)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          lfa_d   = ASZ'(link_q);
          state_d = LNK0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any search in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tib_q   <= '0;
      lfa_q   <= '0;
      pfa_q   <= '0;
      link_q  <= '0;
      tlen_q  <= '0;
      idx_q   <= '0;
      flag_q  <= '0;
      tbyte_q <= '0;
      hops_q  <= '0;
      iss_q   <= 1'b0;
      hit_q   <= 1'b0;
      imm_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tib_q   <= tib_d;
      lfa_q   <= lfa_d;
      pfa_q   <= pfa_d;
      link_q  <= link_d;
      tlen_q  <= tlen_d;
      idx_q   <= idx_d;
      flag_q  <= flag_d;
      tbyte_q <= tbyte_d;
      hops_q  <= hops_d;
      iss_q   <= iss_d;
      hit_q   <= hit_d;
      imm_q   <= imm_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_word_finder.sv
// tb/tb_word_finder.sv - self-checking bench for word_finder
module tb_word_finder;
  import finder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [16:0] tib = '0, ctx = '0;
  logic [16:0] ai_a, ai_b, pfa_a, pfa_b;
  logic [7:0]  vo_a, vo_b, p_b;
  logic        bsy_a, done_a, hit_a, imm_a, err_a;
  logic        bsy_b, done_b, hit_b, imm_b, err_b;
  finder_sts   st_a, st_b;

  logic [7:0]  mem [0:131071];
  logic [7:0]  alpha [0:3];
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  // Instance A: case-sensitive, single-cycle memory, short hop limit.
  word_finder #(.MAX_HOPS(8)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .tib(tib), .ctx(ctx), .mem_ai(ai_a), .mem_vo(vo_a),
    .bsy(bsy_a), .done(done_a), .hit(hit_a), .pfa(pfa_a), .imm(imm_a), .err(err_a), .st(st_a));

  // Instance B: case folding, two-cycle memory.
  word_finder #(.CASE_FOLD(1), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .tib(tib), .ctx(ctx), .mem_ai(ai_b), .mem_vo(vo_b),
    .bsy(bsy_b), .done(done_b), .hit(hit_b), .pfa(pfa_b), .imm(imm_b), .err(err_b), .st(st_b));

  always @(posedge clk) begin
    vo_a <= mem[ai_a];
    p_b  <= mem[ai_b];
    vo_b <= p_b;
  end

  typedef struct {
    string       nm;
    int          sel;
    logic [16:0] t;
    logic [16:0] c;
    logic        eh;
    logic [16:0] ep;
    logic        ei;
    logic        ee;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic put_str(input logic [16:0] a, input string s, input logic [7:0] delim);
    for (int i = 0; i < s.len(); i++) mem[17'(a + 17'(i))] = s[i];
    mem[17'(a + 17'(s.len()))] = delim;
  endtask

  task automatic put_word(input logic [16:0] lfa, input logic [15:0] lnk, input logic [7:0] f,
                          input string s);
    mem[lfa] = lnk[7:0];
    mem[17'(lfa + 1)] = lnk[15:8];
    mem[17'(lfa + 2)] = f;
    for (int i = 0; i < s.len(); i++) mem[17'(lfa + 3 + 17'(i))] = s[i];
  endtask

  function automatic logic [7:0] up(input logic [7:0] b, input bit cf);
    up = (cf && b >= "a" && b <= "z") ? b - 8'd32 : b;
  endfunction

  // Reference: collect the token, then visit words newest-first until a match or the list ends.
  task automatic model(input logic [16:0] t, input logic [16:0] c, input bit cf, input int maxh,
                       output logic h, output logic [16:0] p, output logic im, output logic e);
    int n, vis;
    logic [7:0] b, f;
    logic [16:0] lfa;
    logic [15:0] lnk;
    bit eq;
    h = 0; p = 0; im = 0; e = 0; n = 0;
    forever begin
      b = mem[17'(t + 17'(n))];
      if (b == 8'h00 || b == 8'h20) break;
      if (n == 31) begin e = 1; return; end
      n++;
    end
    if (n == 0 || c == 17'h0ffff) return;
    lfa = c;
    vis = 0;
    forever begin
      vis++;
      f   = mem[17'(lfa + 2)];
      lnk = {mem[17'(lfa + 1)], mem[lfa]};
      if (!f[6] && int'(f[4:0]) == n) begin
        eq = 1;
        for (int i = 0; i < n; i++)
          if (up(mem[17'(t + 17'(i))], cf) != up(mem[17'(lfa + 3 + 17'(i))], cf)) eq = 0;
        if (eq) begin h = 1; p = 17'(lfa + 3 + 17'(n)); im = f[7]; return; end
      end
      if (lnk == 16'hffff) return;
      if (vis == maxh) begin e = 1; return; end
      lfa = {1'b0, lnk};
    end
  endtask

  task automatic run(input int sel, input logic [16:0] t, input logic [16:0] c,
                     output logic h, output logic [16:0] p, output logic im, output logic e,
                     output logic to, output logic b, output finder_sts s);
    @(negedge clk);
    tib = t; ctx = c;
    if (sel == 0) en_a = 1'b1; else en_b = 1'b1;
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if ((sel == 0) ? done_a : done_b) begin to = 1'b0; break; end
      @(negedge clk);
    end
    h  = (sel == 0) ? hit_a : hit_b;
    p  = (sel == 0) ? pfa_a : pfa_b;
    im = (sel == 0) ? imm_a : imm_b;
    e  = (sel == 0) ? err_a : err_b;
    b  = (sel == 0) ? bsy_a : bsy_b;
    s  = (sel == 0) ? st_a : st_b;
  endtask

  task automatic run_chk(input string nm, input int sel, input logic [16:0] t, input logic [16:0] c,
                         input logic eh, input logic [16:0] ep, input logic ei, input logic ee);
    logic h, im, e, to, b;
    logic [16:0] p;
    finder_sts s;
    run(sel, t, c, h, p, im, e, to, b, s);
    chk({nm, "_timeout"}, 32'(to), 32'd0);
    chk({nm, "_hit"}, 32'(h), 32'(eh));
    chk({nm, "_pfa"}, 32'(p), 32'(ep));
    chk({nm, "_imm"}, 32'(im), 32'(ei));
    chk({nm, "_err"}, 32'(e), 32'(ee));
    chk({nm, "_bsy"}, 32'(b), 32'd0);
    chk({nm, "_st"}, 32'(s), 32'(DONE));
  endtask

  task automatic add(input string nm, input int sel, input logic [16:0] t, input logic [16:0] c,
                     input logic eh, input logic [16:0] ep, input logic ei, input logic ee);
    vec_t v;
    v.nm = nm; v.sel = sel; v.t = t; v.c = c; v.eh = eh; v.ep = ep; v.ei = ei; v.ee = ee;
    tbl.push_back(v);
  endtask

  logic [16:0] lfa_r, c_r, ep_r;
  logic [7:0]  nm_r [0:5][0:2];
  int          nl_r [0:5];
  logic        eh_r, ei_r, ee_r;
  string       x31, x32;

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    alpha[0] = "a"; alpha[1] = "A"; alpha[2] = "b"; alpha[3] = "B";
    put_word(17'h10, 16'hffff, 8'h04, "abcd");
    put_word(17'h19, 16'h0010, 8'h04, "efgh");
    put_word(17'h22, 16'h0019, 8'h04, "ijkl");
    put_word(17'h2b, 16'h0022, 8'h04, "mnop");
    x31 = "";
    for (int i = 0; i < 31; i++) x31 = {x31, "x"};
    x32 = {x31, "x"};
    put_str(17'h100, "abcd", 8'h00);
    put_str(17'h110, "mnop", 8'h20);
    put_str(17'h120, "abc", 8'h00);
    put_str(17'h130, "IJKL", 8'h00);
    put_str(17'h140, "AbCd", 8'h00);
    put_str(17'h150, "", 8'h00);
    put_str(17'h160, x32, 8'h00);
    put_str(17'h1c0, x31, 8'h00);
    put_str(17'h1f0, "efgh", 8'h00);
    put_str(17'h1f8, "zzzz", 8'h00);

    repeat (3) @(negedge clk);
    chk("rst_bsy", 32'(bsy_a), 0);   chk("rst_done", 32'(done_a), 0);
    chk("rst_hit", 32'(hit_a), 0);   chk("rst_imm", 32'(imm_a), 0);
    chk("rst_err", 32'(err_a), 0);   chk("rst_pfa", 32'(pfa_a), 0);
    chk("rst_ai", 32'(ai_a), 0);     chk("rst_st", 32'(st_a), 32'(IDLE));
    chk("rst_bsy_b", 32'(bsy_b), 0); chk("rst_ai_b", 32'(ai_b), 0);
    rst = 1'b0;

    add("t1_a",    0, 17'h100, 17'h2b,    1, 17'h10 + 3 + 4, 0, 0);
    add("t1_b",    1, 17'h100, 17'h2b,    1, 17'h10 + 3 + 4, 0, 0);
    add("t2_a",    0, 17'h110, 17'h2b,    1, 17'h2b + 3 + 4, 0, 0);
    add("t2_b",    1, 17'h110, 17'h2b,    1, 17'h2b + 3 + 4, 0, 0);
    add("t2m_a",   0, 17'h120, 17'h2b,    0, 0, 0, 0);
    add("t2m_b",   1, 17'h120, 17'h2b,    0, 0, 0, 0);
    add("t3f_b",   1, 17'h130, 17'h2b,    1, 17'h22 + 3 + 4, 0, 0);
    add("t3n_a",   0, 17'h130, 17'h2b,    0, 0, 0, 0);
    add("mix_b",   1, 17'h140, 17'h2b,    1, 17'h10 + 3 + 4, 0, 0);
    add("mix_a",   0, 17'h140, 17'h2b,    0, 0, 0, 0);
    add("empty_a", 0, 17'h150, 17'h2b,    0, 0, 0, 0);
    add("long_a",  0, 17'h160, 17'h2b,    0, 0, 0, 1);
    add("long_b",  1, 17'h160, 17'h2b,    0, 0, 0, 1);
    add("max31_a", 0, 17'h1c0, 17'h2b,    0, 0, 0, 0);
    add("null_a",  0, 17'h100, 17'hffff,  0, 0, 0, 0);
    add("null_b",  1, 17'h100, 17'hffff,  0, 0, 0, 0);
    foreach (tbl[i]) run_chk(tbl[i].nm, tbl[i].sel, tbl[i].t, tbl[i].c,
                             tbl[i].eh, tbl[i].ep, tbl[i].ei, tbl[i].ee);

    run_chk("empty_a2", 0, 17'h150, 17'h2b, 0, 0, 0, 0);
    chk("empty_no_dict_read", 32'(ai_a), 32'h150);

    mem[17'h1b] = 8'h84;
    run_chk("imm_a", 0, 17'h1f0, 17'h2b, 1, 17'h19 + 3 + 4, 1, 0);
    run_chk("imm_b", 1, 17'h1f0, 17'h2b, 1, 17'h19 + 3 + 4, 1, 0);
    mem[17'h1b] = 8'h44;
    run_chk("hid_a", 0, 17'h1f0, 17'h2b, 0, 0, 0, 0);
    run_chk("hid_b", 1, 17'h1f0, 17'h2b, 0, 0, 0, 0);
    mem[17'h1b] = 8'h04;

    mem[17'h10] = 8'h2b; mem[17'h11] = 8'h00;
    run_chk("loop_a", 0, 17'h1f8, 17'h2b, 0, 0, 0, 1);
    mem[17'h10] = 8'hff; mem[17'h11] = 8'hff;

    @(negedge clk);
    tib = 17'h100; ctx = 17'h2b; en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_bsy_before", 32'(bsy_a), 1);
    rst = 1'b1;
    #1;
    chk("mid_bsy", 32'(bsy_a), 0);
    chk("mid_done", 32'(done_a), 0);
    chk("mid_st", 32'(st_a), 32'(IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_done", 32'(done_a), 0);
    end
    rst = 1'b0;
    run_chk("rerun_t1", 0, 17'h100, 17'h2b, 1, 17'h10 + 3 + 4, 0, 0);

    for (int it = 0; it < 30; it++) begin
      int nw, tl, w;
      nw = $urandom_range(3, 6);
      for (int k = 0; k < nw; k++) begin
        logic [7:0] f;
        logic [16:0] prev;
        lfa_r = 17'h400 + 17'(k * 16);
        prev  = lfa_r - 17'd16;
        nl_r[k] = $urandom_range(1, 3);
        for (int j = 0; j < nl_r[k]; j++) begin
          nm_r[k][j] = alpha[$urandom_range(0, 3)];
          mem[17'(lfa_r + 3 + 17'(j))] = nm_r[k][j];
        end
        f = 8'(nl_r[k]);
        if ($urandom_range(0, 3) == 0) f = f | 8'h40;
        if ($urandom_range(0, 1) == 1) f = f | 8'h80;
        mem[lfa_r] = (k == 0) ? 8'hff : prev[7:0];
        mem[17'(lfa_r + 1)] = (k == 0) ? 8'hff : prev[15:8];
        mem[17'(lfa_r + 2)] = f;
      end
      if ($urandom_range(0, 4) < 3) begin
        w  = $urandom_range(0, nw - 1);
        tl = nl_r[w];
        for (int j = 0; j < tl; j++)
          mem[17'h300 + 17'(j)] = ($urandom_range(0, 3) == 0) ? (nm_r[w][j] ^ 8'h20) : nm_r[w][j];
      end else begin
        tl = $urandom_range(0, 3);
        for (int j = 0; j < tl; j++) mem[17'h300 + 17'(j)] = alpha[$urandom_range(0, 3)];
      end
      mem[17'h300 + 17'(tl)] = ($urandom_range(0, 1) == 1) ? 8'h20 : 8'h00;
      c_r = 17'h400 + 17'((nw - 1) * 16);
      model(17'h300, c_r, (it % 2) == 1, (it % 2 == 0) ? 8 : 1024, eh_r, ep_r, ei_r, ee_r);
      run_chk("rnd", it % 2, 17'h300, c_r, eh_r, ep_r, ei_r, ee_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
